// File: rtl/mem_pkg.sv
// Shared definitions for the unified instruction/data memory responder:
// RV32I funct3 access codes, responder FSM states and the MMIO address.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FFF0;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the memory responder. The store side turns a
// right-aligned store into byte enables plus replicated lane data. The load
// side picks the addressed byte/half out of a word and sign/zero extends it.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  i_st_funct3,
  input  logic [1:0]  i_st_addr_lo,
  input  logic [31:0] i_st_wdata,
  output logic [3:0]  o_st_be,
  output logic [31:0] o_st_wdata,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_ld_word,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_shift;

  assign w_shift = i_ld_word >> {i_ld_addr_lo, 3'b000};

  // Store: byte enables from size/offset, data replicated across all lanes
  always_comb begin
    o_st_be    = 4'b0000;
    o_st_wdata = i_st_wdata;
    case (i_st_funct3)
      F3_B: begin
        o_st_be    = 4'b0001 << i_st_addr_lo;
        o_st_wdata = {4{i_st_wdata[7:0]}};
      end
      F3_H: begin
        o_st_be    = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_st_wdata = {2{i_st_wdata[15:0]}};
      end
      F3_W:    o_st_be = 4'b1111;
      default: o_st_be = 4'b0000;
    endcase
  end

  // Load: shift the addressed lane down, then extend to 32 bits
  always_comb begin
    o_ld_data = 32'd0;
    case (i_ld_funct3)
      F3_B:    o_ld_data = {{24{w_shift[7]}}, w_shift[7:0]};
      F3_BU:   o_ld_data = {24'd0, w_shift[7:0]};
      F3_H:    o_ld_data = {{16{w_shift[15]}}, w_shift[15:0]};
      F3_HU:   o_ld_data = {16'd0, w_shift[15:0]};
      F3_W:    o_ld_data = w_shift;
      default: o_ld_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Unified instruction/data memory for a multicycle RV32I core. Accepts one
// request over valid/ready, commits stores at the accept edge, and returns a
// one-cycle response WAIT_CYCLES+1 cycles later. Illegal size, misaligned and
// out-of-range accesses are rejected with resp_err and have no side effects.
// Optional feature macro MEM_MMIO_EN: adds gpio_out, a word-only register
// mapped at MMIO_ADDR.
module mem_responder
  import mem_pkg::*;
#(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    WAIT_CYCLES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
`ifdef MEM_MMIO_EN
  output logic [31:0] gpio_out,
`endif
  output logic        resp_err
);

  localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_L  = 32'(DEPTH_WORDS);
  localparam logic [3:0]  CNT_LAST = 4'(WAIT_CYCLES - 1);

  logic [31:0]      r_mem [DEPTH_WORDS];
  mem_state_t       r_state;
  logic [3:0]       r_cnt;
  logic             r_ready;
  logic             r_resp_valid;
  logic [31:0]      r_resp_rdata;
  logic             r_resp_err;
  logic             r_we;
  logic [2:0]       r_funct3;
  logic [IDX_W-1:0] r_idx;
  logic [1:0]       r_lo;
  logic             r_err;
  logic             r_mmio;
  logic [31:0]      r_gpio;

  logic             w_accept;
  logic             w_mmio_hit;
  logic             w_req_err;
  logic             w_wr;
  logic [IDX_W-1:0] w_req_idx;
  logic [3:0]       w_st_be;
  logic [31:0]      w_st_wdata;
  logic             w_ld_we;
  logic [2:0]       w_ld_funct3;
  logic [IDX_W-1:0] w_ld_idx;
  logic [1:0]       w_ld_lo;
  logic             w_ld_err;
  logic             w_ld_mmio;
  logic [31:0]      w_ld_word;
  logic [31:0]      w_ld_data;
  logic [31:0]      w_resp_data;

  // Size/alignment/range legality of a request; MMIO hits allow word only
  function automatic logic f_req_err(input logic        we,
                                     input logic [2:0]  f3,
                                     input logic [31:0] a,
                                     input logic        mmio);
    logic e;
    case (f3)
      F3_B:    e = 1'b0;
      F3_H:    e = a[0];
      F3_W:    e = |a[1:0];
      F3_BU:   e = we;
      F3_HU:   e = we | a[0];
      default: e = 1'b1;
    endcase
    if (mmio) begin
      if (f3 != F3_W) e = 1'b1;
    end else if ({2'b00, a[31:2]} >= DEPTH_L) begin
      e = 1'b1;
    end
    return e;
  endfunction

`ifdef MEM_MMIO_EN
  assign w_mmio_hit = (req_addr == MMIO_ADDR);
  assign gpio_out   = r_gpio;
`else
  assign w_mmio_hit = 1'b0;
`endif

  assign w_accept  = reset && (r_state == IDLE) && req_valid;
  assign w_req_err = f_req_err(req_we, req_funct3, req_addr, w_mmio_hit);
  assign w_req_idx = req_addr[IDX_W+1:2];
  assign w_wr      = w_accept && req_we && !w_req_err && !w_mmio_hit;

  // With zero wait states the load is read on the accept edge itself, so the
  // load path looks at the live request in IDLE and the latched copy otherwise
  assign w_ld_we     = (r_state == IDLE) ? req_we     : r_we;
  assign w_ld_funct3 = (r_state == IDLE) ? req_funct3 : r_funct3;
  assign w_ld_idx    = (r_state == IDLE) ? w_req_idx  : r_idx;
  assign w_ld_lo     = (r_state == IDLE) ? req_addr[1:0] : r_lo;
  assign w_ld_err    = (r_state == IDLE) ? w_req_err  : r_err;
  assign w_ld_mmio   = (r_state == IDLE) ? w_mmio_hit : r_mmio;
  assign w_ld_word   = w_ld_mmio ? r_gpio : r_mem[w_ld_idx];
  assign w_resp_data = (w_ld_err || w_ld_we) ? 32'd0 : w_ld_data;

  assign req_ready  = r_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

  mem_lane_align u_align (
    .i_st_funct3  (req_funct3),
    .i_st_addr_lo (req_addr[1:0]),
    .i_st_wdata   (req_wdata),
    .o_st_be      (w_st_be),
    .o_st_wdata   (w_st_wdata),
    .i_ld_funct3  (w_ld_funct3),
    .i_ld_addr_lo (w_ld_lo),
    .i_ld_word    (w_ld_word),
    .o_ld_data    (w_ld_data)
  );

  // Array write port: byte-lane store committed on the accept edge
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (w_st_be[i]) r_mem[w_req_idx][8*i +: 8] <= w_st_wdata[8*i +: 8];
      end
    end
  end

  // MMIO register: legal word store to MMIO_ADDR
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gpio <= 32'd0;
    end else if (w_accept && req_we && w_mmio_hit && !w_req_err) begin
      r_gpio <= req_wdata;
    end
  end

  // Request/response FSM with registered handshake and response outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
      r_we         <= 1'b0;
      r_funct3     <= 3'd0;
      r_idx        <= '0;
      r_lo         <= 2'd0;
      r_err        <= 1'b0;
      r_mmio       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_idx    <= w_req_idx;
            r_lo     <= req_addr[1:0];
            r_err    <= w_req_err;
            r_mmio   <= w_mmio_hit;
            r_cnt    <= 4'd0;
            r_ready  <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              r_state <= BUSY;
            end else begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_rdata <= w_resp_data;
              r_resp_err   <= w_ld_err;
            end
          end
        end
        BUSY: begin
          if (r_cnt == CNT_LAST) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_resp_data;
            r_resp_err   <= w_ld_err;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        RESP: begin
          r_state      <= IDLE;
          r_ready      <= 1'b1;
          r_resp_valid <= 1'b0;
          r_resp_rdata <= 32'd0;
          r_resp_err   <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder (WAIT_CYCLES=1, DEPTH_WORDS=1024).
// The driver pushes each expected response when its request is accepted; an
// independent monitor pops and compares on every resp_valid, and also checks
// accept-to-response latency. MMIO cases follow MEM_MMIO_EN.
module tb_mem_responder;

  localparam int WAIT = 1;
  localparam int DEPTH = 1024;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
`ifdef MEM_MMIO_EN
  logic [31:0] gpio_out;
`endif

  int   tests = 0;
  int   fails = 0;
  int   ncount = 0;
  exp_t exp_q[$];
  int   acc_q[$];

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
`ifdef MEM_MMIO_EN
    .gpio_out   (gpio_out),
`endif
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Drive one request, hold it until accepted, optionally queue its expectation
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee,
                       input bit push);
    int n;
    n = 0;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(negedge clk);
    while (!req_ready) begin
      n++;
      if (n > 50) begin
        chk("accept_timeout", {31'd0, req_ready}, 32'd1);
        break;
      end
      @(negedge clk);
    end
    if (push) exp_q.push_back('{er, ee});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Monitor: compare every response against the scoreboard and its latency
  initial begin : monitor
    exp_t e;
    int   a;
    forever begin
      @(negedge clk);
      ncount++;
      if (reset && resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", {31'd0, resp_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
          if (acc_q.size() != 0) begin
            a = acc_q.pop_front();
            chk("resp_latency", 32'(ncount - a), 32'(WAIT + 1));
          end
        end
      end
      if (reset && req_valid && req_ready) acc_q.push_back(ncount);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
`ifdef MEM_MMIO_EN
    chk("rst_gpio", gpio_out, 32'd0);
`endif
    reset = 1'b1;
    @(posedge clk);
    #1;

    // word store/load
    issue(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1);
    issue(0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1);
    // byte store into lane 3, sign/zero extended loads
    issue(1, 3'b000, 32'h13, 32'h00000080, 32'h0, 0, 1);
    issue(0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 0, 1);
    issue(0, 3'b100, 32'h13, 32'h0, 32'h00000080, 0, 1);
    issue(0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 0, 1);
    issue(0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFBE, 0, 1);
    issue(0, 3'b101, 32'h12, 32'h0, 32'h000080AD, 0, 1);
    issue(0, 3'b001, 32'h12, 32'h0, 32'hFFFF80AD, 0, 1);
    // misaligned accesses leave word 0x20 intact
    issue(1, 3'b010, 32'h20, 32'h11223344, 32'h0, 0, 1);
    issue(1, 3'b001, 32'h21, 32'h0000AAAA, 32'h0, 1, 1);
    issue(0, 3'b010, 32'h22, 32'h0, 32'h0, 1, 1);
    issue(0, 3'b001, 32'h23, 32'h0, 32'h0, 1, 1);
    issue(0, 3'b010, 32'h20, 32'h0, 32'h11223344, 0, 1);
    // aligned upper half and low byte
    issue(1, 3'b001, 32'h22, 32'h0000BEEF, 32'h0, 0, 1);
    issue(0, 3'b001, 32'h22, 32'h0, 32'hFFFFBEEF, 0, 1);
    issue(0, 3'b101, 32'h22, 32'h0, 32'h0000BEEF, 0, 1);
    issue(1, 3'b000, 32'h20, 32'h0000007F, 32'h0, 0, 1);
    issue(0, 3'b010, 32'h20, 32'h0, 32'hBEEF337F, 0, 1);
    issue(0, 3'b000, 32'h20, 32'h0, 32'h0000007F, 0, 1);
    // out of range, with ready held low through BUSY and RESP
    issue(0, 3'b010, 32'h1000, 32'h0, 32'h0, 1, 1);
    chk("ready_busy", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("ready_resp", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    // illegal funct3 encodings and unsigned stores do not write
    issue(0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 1);
    issue(1, 3'b010, 32'h40, 32'h00000000, 32'h0, 0, 1);
    issue(1, 3'b100, 32'h40, 32'h000000FF, 32'h0, 1, 1);
    issue(1, 3'b111, 32'h40, 32'hFFFFFFFF, 32'h0, 1, 1);
    issue(0, 3'b110, 32'h40, 32'h0, 32'h0, 1, 1);
    issue(0, 3'b010, 32'h40, 32'h0, 32'h00000000, 0, 1);
    // last word in range, first word past it
    issue(1, 3'b010, 32'hFFC, 32'hCAFEF00D, 32'h0, 0, 1);
    issue(1, 3'b010, 32'h1000, 32'h55555555, 32'h0, 1, 1);
    issue(0, 3'b010, 32'hFFC, 32'h0, 32'hCAFEF00D, 0, 1);

    // reset in BUSY drops the response but keeps the committed store
    issue(1, 3'b010, 32'h30, 32'h12345678, 32'h0, 0, 0);
    reset = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    repeat (2) @(posedge clk);
    acc_q.delete();
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    issue(0, 3'b010, 32'h30, 32'h0, 32'h12345678, 0, 1);

`ifdef MEM_MMIO_EN
    issue(1, 3'b010, 32'hFFFFFFF0, 32'h000000A5, 32'h0, 0, 1);
    chk("gpio_after_sw", gpio_out, 32'h000000A5);
    issue(0, 3'b010, 32'hFFFFFFF0, 32'h0, 32'h000000A5, 0, 1);
    issue(1, 3'b000, 32'hFFFFFFF0, 32'h0000005A, 32'h0, 1, 1);
    issue(0, 3'b001, 32'hFFFFFFF0, 32'h0, 32'h0, 1, 1);
    chk("gpio_kept", gpio_out, 32'h000000A5);
`else
    issue(1, 3'b010, 32'hFFFFFFF0, 32'h000000A5, 32'h0, 1, 1);
    issue(0, 3'b010, 32'hFFFFFFF0, 32'h0, 32'h0, 1, 1);
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
